// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM generator.
// Align mode encoding used by the shadow and active align registers.
package pwm_pkg;

    localparam logic ALIGN_EDGE   = 1'b0;
    localparam logic ALIGN_CENTER = 1'b1;

endpackage

// File: rtl/pwm_multi_if.sv
// Control/output bundle of pwm_multi.
// master = register/control side, slave = the PWM generator itself.
interface pwm_multi_if #(
    parameter int CH = 4,
    parameter int CW = 8
);

    logic              en;
    logic              align_i;
    logic [CW-1:0]     period_i;
    logic [CH*CW-1:0]  duty_i;
    logic              load_i;
    logic              sweep_i;
    logic [CH-1:0]     pwm_o;
    logic              cyc_o;
    logic              load_ack_o;

    modport master (
        output en, align_i, period_i, duty_i, load_i, sweep_i,
        input  pwm_o, cyc_o, load_ack_o
    );

    modport slave (
        input  en, align_i, period_i, duty_i, load_i, sweep_i,
        output pwm_o, cyc_o, load_ack_o
    );

endinterface

// File: rtl/pwm_cmp_ch.sv
// One PWM compare channel: active duty register, optional duty sweep and
// the registered output compare (cnt < duty).
// Optional feature macro: PWM_SWEEP_EN (adds the STEP duty sweep adder).
module pwm_cmp_ch #(
    parameter int CW   = 8,
    parameter int STEP = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [CW-1:0] cnt_i,
    input  logic          apply_i,
    input  logic [CW-1:0] dutyNew_i,
    input  logic          sweepTick_i,
    input  logic [CW-1:0] periodAct_i,
    output logic          pwm_o
);

    logic [CW-1:0] duty_q;
    logic [CW-1:0] duty_d;
    logic          pwm_q;

`ifdef PWM_SWEEP_EN
    logic [CW:0] dutyStep;

    // Duty plus one sweep step, one bit wider so a CW-bit overflow is visible.
    always_comb begin
        dutyStep = {1'b0, duty_q} + (CW+1)'(STEP);
    end
`else
    localparam int unusedStep = STEP;
    logic unusedSweep;
    assign unusedSweep = ^{sweepTick_i, periodAct_i};
`endif

    // Next duty: a pending load wins; otherwise the sweep ramps and folds to 0.
    always_comb begin
        duty_d = duty_q;
        if (apply_i) begin
            duty_d = dutyNew_i;
        end
`ifdef PWM_SWEEP_EN
        else if (sweepTick_i) begin
            duty_d = (dutyStep > {1'b0, periodAct_i}) ? '0 : dutyStep[CW-1:0];
        end
`endif
    end

    // Duty register and output compare flop; output forced low while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= en_i && (cnt_i < duty_q);
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared edge/center-aligned period counter,
// double-buffered period/duty/align updates at cycle boundaries, run enable.
// Optional feature macro: PWM_SWEEP_EN (automatic duty sweep when sweep_i=1).
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH         = 4,
    parameter int CW         = 8,
    parameter int PERIOD_RST = 99,
    parameter int STEP       = 5
) (
    input logic        clk,
    input logic        rst,
    pwm_multi_if.slave bus
);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dirDown_q, dirDown_d;
    logic [CW-1:0]    periodAct_q;
    logic             alignAct_q;
    logic             pending_q, pending_d;
    logic [CW-1:0]    periodShd_q;
    logic [CH*CW-1:0] dutyShd_q;
    logic             alignShd_q;
    logic             cyc_q;
    logic             loadAck_q;
    logic             lastCount;
    logic             apply;
    logic             sweepTick;
    logic [CH-1:0]    pwmBits;

    // Last count of a cycle: top in edge mode (or tiny periods), 1 on the way down in center mode.
    always_comb begin
        lastCount = 1'b0;
        if (bus.en) begin
            if ((alignAct_q == ALIGN_EDGE) || (periodAct_q <= CW'(1))) begin
                lastCount = (cnt_q == periodAct_q);
            end else begin
                lastCount = dirDown_q && (cnt_q == CW'(1));
            end
        end
    end

    // Shadow values go live at a boundary, or immediately while disabled.
    always_comb begin
        apply     = pending_q && (lastCount || !bus.en);
        pending_d = bus.load_i ? 1'b1 : (apply ? 1'b0 : pending_q);
    end

    // Counter sequencing: restart at 0 going up on a boundary or while disabled.
    always_comb begin
        cnt_d     = cnt_q;
        dirDown_d = dirDown_q;
        if (!bus.en || lastCount) begin
            cnt_d     = '0;
            dirDown_d = 1'b0;
        end else if ((alignAct_q == ALIGN_CENTER) && !dirDown_q && (cnt_q == periodAct_q)) begin
            cnt_d     = cnt_q - CW'(1);
            dirDown_d = 1'b1;
        end else if (dirDown_q) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

`ifdef PWM_SWEEP_EN
    assign sweepTick = lastCount && !apply && bus.sweep_i;
`else
    logic unusedSweep;
    assign unusedSweep = bus.sweep_i;
    assign sweepTick   = 1'b0;
`endif

    // Counter, shadow registers, active period/align and the cycle/ack pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            dirDown_q   <= 1'b0;
            periodAct_q <= CW'(PERIOD_RST);
            alignAct_q  <= ALIGN_EDGE;
            pending_q   <= 1'b0;
            periodShd_q <= '0;
            dutyShd_q   <= '0;
            alignShd_q  <= ALIGN_EDGE;
            cyc_q       <= 1'b0;
            loadAck_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dirDown_q <= dirDown_d;
            pending_q <= pending_d;
            cyc_q     <= lastCount;
            loadAck_q <= apply;
            if (bus.load_i) begin
                periodShd_q <= bus.period_i;
                dutyShd_q   <= bus.duty_i;
                alignShd_q  <= bus.align_i;
            end
            if (apply) begin
                periodAct_q <= periodShd_q;
                alignAct_q  <= alignShd_q;
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : gCh
        pwm_cmp_ch #(
            .CW   (CW),
            .STEP (STEP)
        ) uCh (
            .clk         (clk),
            .rst         (rst),
            .en_i        (bus.en),
            .cnt_i       (cnt_q),
            .apply_i     (apply),
            .dutyNew_i   (dutyShd_q[k*CW +: CW]),
            .sweepTick_i (sweepTick),
            .periodAct_i (periodAct_q),
            .pwm_o       (pwmBits[k])
        );
    end

    assign bus.pwm_o      = pwmBits;
    assign bus.cyc_o      = cyc_q;
    assign bus.load_ack_o = loadAck_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus randomized
// stimulus checked every clock against a cycle-phase reference model.
// Optional feature macro: PWM_SWEEP_EN (changes expected sweep behaviour).
module tb_pwm_multi;

    localparam int CH   = 4;
    localparam int CW   = 8;
    localparam int PRST = 99;
    localparam int STEP = 5;
`ifdef PWM_SWEEP_EN
    localparam bit SWEEP_ON = 1'b1;
`else
    localparam bit SWEEP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    pwm_multi_if #(.CH(CH), .CW(CW)) bus ();

    pwm_multi #(
        .CH         (CH),
        .CW         (CW),
        .PERIOD_RST (PRST),
        .STEP       (STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the cycle plus active/shadow values
    int mPhase, mP, mAlign, mPending, mShP, mShA;
    int mDuty[CH];
    int mShD[CH];
    logic [CH-1:0] expPwm;
    logic          expCyc, expAck;

    // Running observation totals
    int cycTotal = 0;
    int ackTotal = 0;
    int highs[CH];
    int winHigh[CH];
    int winCyc;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance the model by one clock using the inputs present at that edge
    task automatic modelStep();
        int len;
        int cnt;
        bit last;
        bit apply;
        if (rst) begin
            mPhase = 0; mP = PRST; mAlign = 0; mPending = 0;
            for (int k = 0; k < CH; k++) mDuty[k] = 0;
            expPwm = '0; expCyc = 1'b0; expAck = 1'b0;
        end else begin
            len = (mAlign == 1 && mP > 0) ? 2 * mP : mP + 1;
            cnt = (mPhase <= mP) ? mPhase : 2 * mP - mPhase;
            for (int k = 0; k < CH; k++) expPwm[k] = bus.en && (cnt < mDuty[k]);
            last   = bus.en && (mPhase == len - 1);
            apply  = (mPending == 1) && (last || !bus.en);
            expCyc = last;
            expAck = apply;
            if (apply) begin
                mP = mShP; mAlign = mShA;
                for (int k = 0; k < CH; k++) mDuty[k] = mShD[k];
            end else if (SWEEP_ON && last && bus.sweep_i) begin
                for (int k = 0; k < CH; k++)
                    mDuty[k] = (mDuty[k] + STEP > mP) ? 0 : mDuty[k] + STEP;
            end
            if (bus.load_i) begin
                mShP = int'(bus.period_i);
                mShA = int'(bus.align_i);
                for (int k = 0; k < CH; k++) mShD[k] = int'(bus.duty_i[k*CW +: CW]);
                mPending = 1;
            end else if (apply) begin
                mPending = 0;
            end
            mPhase = (!bus.en || last) ? 0 : mPhase + 1;
        end
    endtask

    // One clock: model update at the edge, DUT sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("pwm", int'(bus.pwm_o), int'(expPwm));
        checkOutput("cyc", int'(bus.cyc_o), int'(expCyc));
        checkOutput("ack", int'(bus.load_ack_o), int'(expAck));
        cycTotal += int'(bus.cyc_o);
        ackTotal += int'(bus.load_ack_o);
        for (int k = 0; k < CH; k++) highs[k] += int'(bus.pwm_o[k]);
    endtask

    task automatic runWindow(input int n);
        int h0[CH];
        int c0;
        for (int k = 0; k < CH; k++) h0[k] = highs[k];
        c0 = cycTotal;
        repeat (n) tick();
        for (int k = 0; k < CH; k++) winHigh[k] = highs[k] - h0[k];
        winCyc = cycTotal - c0;
    endtask

    task automatic waitCyc(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.cyc_o && n < budget);
        if (!bus.cyc_o) checkOutput("cycTimeout", 0, 1);
    endtask

    task automatic waitAck(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.load_ack_o && n < budget);
        if (!bus.load_ack_o) checkOutput("ackTimeout", 0, 1);
    endtask

    task automatic applyStimulus(input int p, input logic [CH*CW-1:0] d, input bit al);
        bus.period_i = CW'(p);
        bus.duty_i   = d;
        bus.align_i  = al;
        bus.load_i   = 1'b1;
        tick();
        bus.load_i   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int ack0;
        int sweepExp[5];
        sweepExp = '{0, 5, 10, 15, 0};
        for (int k = 0; k < CH; k++) highs[k] = 0;

        rst = 1'b1;
        bus.en = 1'b0; bus.load_i = 1'b0; bus.align_i = 1'b0;
        bus.period_i = '0; bus.duty_i = '0; bus.sweep_i = 1'b0;
        tick();
        tick();
        checkOutput("rstPwm", int'(bus.pwm_o), 0);
        checkOutput("rstCyc", int'(bus.cyc_o), 0);
        rst = 1'b0;
        bus.en = 1'b1;

        // Reset period 99, edge aligned
        waitCyc(200, n);
        waitCyc(200, n);
        checkOutput("edgeP99Len", n, 100);

        // P=9 with duties 3, 0, 10, 9
        applyStimulus(9, {8'd9, 8'd10, 8'd0, 8'd3}, 1'b0);
        waitAck(200, n);
        runWindow(10);
        checkOutput("ch0High", winHigh[0], 3);
        checkOutput("ch1High", winHigh[1], 0);
        checkOutput("ch2High", winHigh[2], 10);
        checkOutput("ch3High", winHigh[3], 9);
        checkOutput("p9CycCount", winCyc, 1);

        // Mid-cycle double load at cnt=4: old period finishes, last values win
        runWindow(4);
        ack0 = ackTotal;
        applyStimulus(19, {8'd9, 8'd10, 8'd0, 8'd3}, 1'b0);
        applyStimulus(19, {8'd0, 8'd0, 8'd0, 8'd5}, 1'b0);
        waitCyc(50, n);
        checkOutput("oldPeriodDone", n, 4);
        checkOutput("ackWithBoundary", int'(bus.load_ack_o), 1);
        waitCyc(50, n);
        checkOutput("newPeriodLen", n, 20);
        checkOutput("singleAck", ackTotal - ack0, 1);
        runWindow(20);
        checkOutput("lastLoadWins", winHigh[0], 5);

        // Center aligned, P=8, duty0=3
        applyStimulus(8, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b1);
        waitAck(100, n);
        runWindow(16);
        checkOutput("centerHigh", winHigh[0], 5);
        checkOutput("centerCycCount", winCyc, 1);
        waitCyc(40, n);
        checkOutput("centerLen", n, 16);

        // Enable low mid-cycle, then restart from cnt 0
        applyStimulus(9, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b0);
        waitAck(100, n);
        runWindow(4);
        bus.en = 1'b0;
        runWindow(7);
        checkOutput("disabledHigh", winHigh[0], 0);
        checkOutput("disabledCyc", winCyc, 0);
        bus.en = 1'b1;
        tick();
        checkOutput("enRestartFirst", int'(bus.pwm_o[0]), 1);
        runWindow(9);
        checkOutput("enRestartHigh", winHigh[0], 2);

        // Reset at cnt=5 with a load pending
        runWindow(5);
        applyStimulus(40, {8'd7, 8'd7, 8'd7, 8'd7}, 1'b0);
        ack0 = ackTotal;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        waitCyc(200, n);
        waitCyc(200, n);
        checkOutput("rstPeriodLen", n, 100);
        checkOutput("rstDropsPending", ackTotal - ack0, 0);

        // Duty sweep
        applyStimulus(19, '0, 1'b0);
        waitAck(200, n);
        bus.sweep_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            runWindow(20);
            checkOutput("sweepDuty", winHigh[0], SWEEP_ON ? sweepExp[i] : 0);
        end
        bus.sweep_i = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int p;
            rst         = ($urandom_range(0, 299) == 0);
            bus.en      = ($urandom_range(0, 9) != 0);
            bus.load_i  = ($urandom_range(0, 29) == 0);
            if (bus.load_i) begin
                p = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 24));
                bus.period_i = CW'(p);
                for (int k = 0; k < CH; k++)
                    bus.duty_i[k*CW +: CW] = CW'($urandom_range(0, (p + 3 > 255) ? 255 : p + 3));
                bus.align_i = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 99) == 0) bus.sweep_i = ~bus.sweep_i;
            tick();
        end
        rst = 1'b0;
        bus.load_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
